pll_divn_sequencer: RTL and testbench



---
 rtl/pll_divn_sequencer_if.sv | 37 +++
 rtl/pll_divn_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_pll_divn_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/pll_divn_sequencer_if.sv
// Purpose : bundles the request, droop and PLL-control signals of pll_divn_sequencer.
// Latency : n/a (wiring only).
// Backpressure: target_valid is held by the master until target_ready is seen high at a clock edge.
//
// Ports (master = requester / testbench, slave = sequencer):
//   target_divn  master->slave  requested divide ratio
//   target_valid master->slave  request strobe, held until accepted
//   droop_req    master->slave  synchronous supply-droop indication
//   target_ready slave->master  high only while the sequencer is idle
//   pll_resetn   slave->master  PLL resetn
//   divn         slave->master  PLL divide ratio (registered)
//   brake        slave->master  PLL brake (registered)
//   busy         slave->master  high whenever the sequencer is not idle
//   done         slave->master  one-cycle pulse when divn reaches the accepted target
interface pll_divn_sequencer_if #(
  parameter int DIVN_W = 8
);
  logic [DIVN_W-1:0] target_divn;
  logic              target_valid;
  logic              target_ready;
  logic              droop_req;
  logic              pll_resetn;
  logic [DIVN_W-1:0] divn;
  logic              brake;
  logic              busy;
  logic              done;

  modport master (
    output target_divn, target_valid, droop_req,
    input  target_ready, pll_resetn, divn, brake, busy, done
  );

  modport slave (
    input  target_divn, target_valid, droop_req,
    output target_ready, pll_resetn, divn, brake, busy, done
  );
endinterface

// File: rtl/pll_divn_sequencer.sv
// Purpose : holds the PLL in reset, then slews divn one unit per (DWELL+1) refclk cycles toward a clamped target; turns droop rising edges into brake pulses.
// Latency : accept at t0 -> divn steps at t0+1+i*(DWELL+1); done/target_ready at t0+1+n*(DWELL+1) (t0+1 when already at target).
// Backpressure: target_ready is low outside IDLE, requests are left pending (not dropped); brake freezes the dwell timer only.
//
// Ports:
//   refclk  sole clock, rising edge
//   reset   asynchronous active-high reset
//   bus     pll_divn_sequencer_if.slave (target_divn/valid/ready, droop_req, pll_resetn, divn, brake, busy, done)
// DIVN_W must match the DIVN_W of the connected interface instance.
module pll_divn_sequencer #(
  parameter int DIVN_W       = 8,
  parameter int DIVN_DEFAULT = 45,
  parameter int DIVN_MIN     = 8,
  parameter int DIVN_MAX     = 255,
  parameter int RST_HOLD     = 100,
  parameter int DWELL        = 64,
  parameter int BRAKE_LEN    = 2
) (
  input logic                 refclk,
  input logic                 reset,
  pll_divn_sequencer_if.slave bus
);

  localparam int HOLD_W  = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int BRAKE_W = $clog2(BRAKE_LEN + 1);

  localparam logic [DIVN_W-1:0]  DEF_V      = DIVN_W'(DIVN_DEFAULT);
  localparam logic [DIVN_W-1:0]  MIN_V      = DIVN_W'(DIVN_MIN);
  localparam logic [DIVN_W-1:0]  MAX_V      = DIVN_W'(DIVN_MAX);
  localparam logic [DIVN_W-1:0]  DIVN_ONE   = DIVN_W'(1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RST_HOLD - 1);
  localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);
  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL - 1);
  localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);
  localparam logic [BRAKE_W-1:0] BRAKE_LOAD = BRAKE_W'(BRAKE_LEN);
  localparam logic [BRAKE_W-1:0] BRAKE_ONE  = BRAKE_W'(1);

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_IDLE  = 2'd1,
    S_STEP  = 2'd2,
    S_DWELL = 2'd3
  } state_t;

  state_t             state_q;
  logic [HOLD_W-1:0]  hold_cnt_q;
  logic [DWELL_W-1:0] dwell_cnt_q;
  logic [BRAKE_W-1:0] brake_cnt_q;
  logic [DIVN_W-1:0]  tgt_q;
  logic [DIVN_W-1:0]  divn_q;
  logic               pll_resetn_q;
  logic               brake_q;
  logic               ready_q;
  logic               busy_q;
  logic               done_q;
  logic               done_pend_q;
  logic               droop_prev_q;

  logic [DIVN_W-1:0]  tgt_clamp_d;
  logic [DIVN_W-1:0]  divn_step_d;
  logic [BRAKE_W-1:0] brake_cnt_d;
  logic               droop_rise;

  // Compare in int so the clamp stays well-formed when a bound equals the full DIVN_W range.
  always_comb begin
    tgt_clamp_d = bus.target_divn;
    if (int'(bus.target_divn) < DIVN_MIN) begin
      tgt_clamp_d = MIN_V;
    end else if (int'(bus.target_divn) > DIVN_MAX) begin
      tgt_clamp_d = MAX_V;
    end
  end

  always_comb begin
    divn_step_d = (divn_q < tgt_q) ? (divn_q + DIVN_ONE) : (divn_q - DIVN_ONE);
  end

  // Droop edges are ignored while the PLL is still held in reset.
  assign droop_rise = bus.droop_req && !droop_prev_q && (state_q != S_HOLD);

  // A new rising edge reloads the counter, so overlapping droops stretch one pulse.
  always_comb begin
    brake_cnt_d = brake_cnt_q;
    if (droop_rise) begin
      brake_cnt_d = BRAKE_LOAD;
    end else if (brake_cnt_q != '0) begin
      brake_cnt_d = brake_cnt_q - BRAKE_ONE;
    end
  end

  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      state_q      <= S_HOLD;
      hold_cnt_q   <= '0;
      dwell_cnt_q  <= '0;
      brake_cnt_q  <= '0;
      tgt_q        <= DEF_V;
      divn_q       <= DEF_V;
      pll_resetn_q <= 1'b0;
      brake_q      <= 1'b0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      done_pend_q  <= 1'b0;
      droop_prev_q <= 1'b0;
    end else begin
      droop_prev_q <= bus.droop_req;
      brake_cnt_q  <= brake_cnt_d;
      brake_q      <= (brake_cnt_d != '0);
      // A request that already matches divn reports done one cycle after acceptance.
      done_q       <= done_pend_q;
      done_pend_q  <= 1'b0;

      case (state_q)
        S_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_q      <= S_IDLE;
            pll_resetn_q <= 1'b1;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_ONE;
          end
        end

        S_IDLE: begin
          if (bus.target_valid && ready_q) begin
            tgt_q <= tgt_clamp_d;
            if (tgt_clamp_d == divn_q) begin
              done_pend_q <= 1'b1;
            end else begin
              state_q <= S_STEP;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
        end

        // Completion is reported from STEP so that done lands one full
        // step period after the last divn change, on the same grid as the steps.
        S_STEP: begin
          if (divn_q == tgt_q) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            divn_q      <= divn_step_d;
            dwell_cnt_q <= DWELL_LOAD;
            state_q     <= S_DWELL;
          end
        end

        S_DWELL: begin
          // Brake freezes the dwell timer, including its terminal count.
          if (!brake_q) begin
            if (dwell_cnt_q == '0) begin
              state_q <= S_STEP;
            end else begin
              dwell_cnt_q <= dwell_cnt_q - DWELL_ONE;
            end
          end
        end

        default: begin
          state_q <= S_HOLD;
        end
      endcase
    end
  end

  assign bus.target_ready = ready_q;
  assign bus.pll_resetn   = pll_resetn_q;
  assign bus.divn         = divn_q;
  assign bus.brake        = brake_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_pll_divn_sequencer.sv
// Purpose : self-checking bench for pll_divn_sequencer with directed and randomized requests and droop.
// Latency : expected per-edge timeline is computed up front for each request from the step/dwell/brake timing rules.
// Backpressure: requests are held through busy periods to confirm they are neither accepted early nor lost.
module tb_pll_divn_sequencer;

  localparam int DIVN_W = 8;
  localparam int DEF    = 45;
  localparam int DMIN   = 8;
  localparam int DMAX   = 200;
  localparam int HOLD   = 100;
  localparam int DW     = 4;
  localparam int BL     = 2;
  localparam int MAXE   = 8192;

  logic refclk = 1'b0;
  logic reset;

  int checks = 0;
  int errors = 0;
  int m_divn;
  int m_last;

  bit drq [0:MAXE-1];
  bit brk [0:MAXE-1];
  int dv  [0:MAXE-1];

  pll_divn_sequencer_if #(.DIVN_W(DIVN_W)) bus ();

  pll_divn_sequencer #(
    .DIVN_W      (DIVN_W),
    .DIVN_DEFAULT(DEF),
    .DIVN_MIN    (DMIN),
    .DIVN_MAX    (DMAX),
    .RST_HOLD    (HOLD),
    .DWELL       (DW),
    .BRAKE_LEN   (BL)
  ) dut (
    .refclk(refclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string ph, input int e_div, input bit e_brk,
                          input bit e_busy, input bit e_done, input bit e_rstn);
    chk({ph, ".divn"},       bus.divn,         e_div);
    chk({ph, ".brake"},      bus.brake,        e_brk);
    chk({ph, ".busy"},       bus.busy,         e_busy);
    chk({ph, ".done"},       bus.done,         e_done);
    chk({ph, ".ready"},      bus.target_ready, e_rstn && !e_busy);
    chk({ph, ".pll_resetn"}, bus.pll_resetn,   e_rstn);
  endtask

  // Reset asserted between edges, then the full hold sequence with a droop burst inside it.
  task automatic do_reset();
    reset = 1'b1;
    bus.target_valid = 1'b0;
    bus.droop_req = 1'b0;
    #1;
    chk_outs("rst_async", DEF, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    chk_outs("rst_held", DEF, 1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    for (int e = 1; e <= HOLD; e++) begin
      bus.droop_req = (e >= 40 && e < 44);
      tick();
      chk_outs($sformatf("hold%0d", e), DEF, 1'b0, e != HOLD, 1'b0, e == HOLD);
    end
    bus.droop_req = 1'b0;
    m_divn = DEF;
  endtask

  task automatic idle(input int cnt, input string ph);
    bus.target_valid = 1'b0;
    bus.droop_req = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      tick();
      chk_outs(ph, m_divn, 1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  // Expected droop level, brake level and divn after edge t0+e.
  task automatic gen_edge(input int e, input bit rnd, input logic [31:0] dmask,
                          input int span, input int cur);
    logic [31:0] m;
    logic [4:0]  bi;
    bit          d;
    m  = dmask;
    bi = e[4:0];
    d  = (e < 32) ? m[bi] : 1'b0;
    if (rnd && e <= span && $urandom_range(0, 3) == 0) d = 1'b1;
    drq[e] = d;
    if (drq[e] && !drq[e-1]) m_last = e;
    brk[e] = (e - m_last) < BL;
    dv[e]  = cur;
  endtask

  task automatic do_req(input int tgt_in, input bit rnd, input logic [31:0] dmask,
                        input bit hold_next, input int next_tgt, input int abort_at);
    int    tgt, n, sgn, cur, e, unb, done_e, end_e, span;
    string ph;
    ph   = $sformatf("req%0d", tgt_in);
    tgt  = (tgt_in < DMIN) ? DMIN : ((tgt_in > DMAX) ? DMAX : tgt_in);
    n    = (tgt > m_divn) ? (tgt - m_divn) : (m_divn - tgt);
    sgn  = (tgt > m_divn) ? 1 : -1;
    span = n * (DW + 1);
    cur  = m_divn;
    m_last = -1000;
    drq[0] = 1'b0;
    brk[0] = 1'b0;
    dv[0]  = cur;
    e = 0;
    if (n == 0) begin
      done_e = 1;
      gen_edge(1, 1'b0, 32'd0, 0, cur);
    end else begin
      // Each step: one edge moves divn, then DW edges with brake low must elapse.
      for (int s = 0; s < n; s++) begin
        e++;
        cur += sgn;
        gen_edge(e, rnd, dmask, span, cur);
        unb = 0;
        while (unb < DW) begin
          e++;
          gen_edge(e, rnd, dmask, span, cur);
          if (!brk[e-1]) unb++;
        end
      end
      e++;
      gen_edge(e, 1'b0, 32'd0, 0, cur);
      done_e = e;
    end
    end_e = hold_next ? done_e : (done_e + BL + 2);
    for (int k = done_e + 1; k <= end_e; k++) gen_edge(k, 1'b0, 32'd0, 0, cur);

    bus.target_divn  = DIVN_W'(tgt_in);
    bus.target_valid = 1'b1;
    bus.droop_req    = drq[0];
    tick();
    chk_outs({ph, ".t0"}, dv[0], brk[0], n != 0, 1'b0, 1'b1);
    bus.target_valid = hold_next;
    if (hold_next) bus.target_divn = DIVN_W'(next_tgt);
    for (int k = 1; k <= end_e; k++) begin
      bus.droop_req = drq[k];
      tick();
      chk_outs(ph, dv[k], brk[k], (n != 0) && (k < done_e), k == done_e, 1'b1);
      if (k == abort_at) break;
    end
    bus.droop_req = 1'b0;
    m_divn = cur;
  endtask

  initial begin
    reset = 1'b0;
    bus.target_valid = 1'b0;
    bus.target_divn  = '0;
    bus.droop_req    = 1'b0;
    m_divn = DEF;
    m_last = -1000;
    #2;
    do_reset();
    idle(3, "idle0");

    // Upward slew of three steps, then back down.
    do_req(48, 1'b0, 32'd0, 1'b0, 0, -1);
    do_req(45, 1'b0, 32'd0, 1'b0, 0, -1);
    // 43 from 45 with the next request held through the busy window, then already-at-target.
    do_req(43, 1'b0, 32'd0, 1'b1, 43, -1);
    do_req(43, 1'b0, 32'd0, 1'b0, 0, -1);
    idle(3, "idle1");

    // Lower and upper clamps.
    do_req(10, 1'b0, 32'd0, 1'b0, 0, -1);
    do_req(3, 1'b0, 32'd0, 1'b0, 0, -1);
    do_req(0, 1'b0, 32'd0, 1'b0, 0, -1);
    do_req(250, 1'b0, 32'd0, 1'b0, 0, -1);
    do_req(201, 1'b0, 32'd0, 1'b0, 0, -1);

    // Droop mid-dwell: single rise, re-rise while braking, long level with one rise.
    do_req(199, 1'b0, 32'h0000_0004, 1'b0, 0, -1);
    do_req(198, 1'b0, 32'h0000_0014, 1'b0, 0, -1);
    do_req(197, 1'b0, 32'h0000_007C, 1'b0, 0, -1);

    // Reset mid-slew once divn has reached 47; the old target must not resume.
    do_req(45, 1'b0, 32'd0, 1'b0, 0, -1);
    do_req(48, 1'b0, 32'd0, 1'b0, 0, 6);
    do_reset();
    idle(20, "no_resume");

    // Randomized targets, every other one with random droop.
    for (int i = 0; i < 12; i++) begin
      do_req(int'($urandom_range(0, 255)), i[0], 32'd0, 1'b0, 0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
